// File: rtl/svm_stream_classifier_if.sv
// svm_stream_classifier_if: config, test-vector and result ports of the SVM classifier
interface svm_stream_classifier_if #(
  parameter int DATA_W   = 16,
  parameter int ACCUM_W  = 40,
  parameter int NUM_FEAT = 2,
  parameter int NUM_SV   = 3,
  parameter int TAG_W    = 8
);
  localparam int AW = NUM_SV > 1 ? $clog2(NUM_SV) : 1;
  logic                         cfg_we;
  logic [AW-1:0]                cfg_addr;
  logic [NUM_FEAT*DATA_W-1:0]   cfg_sv;
  logic [DATA_W-1:0]            cfg_alpha;
  logic                         cfg_bias_we;
  logic [DATA_W-1:0]            cfg_bias;
  logic                         cfg_ready;
  logic                         s_valid;
  logic                         s_ready;
  logic [NUM_FEAT*DATA_W-1:0]   s_data;
  logic                         m_valid;
  logic                         m_ready;
  logic [ACCUM_W-1:0]           m_score;
  logic                         m_class;
  logic [TAG_W-1:0]             m_tag;
  modport master (
    output cfg_we, cfg_addr, cfg_sv, cfg_alpha, cfg_bias_we, cfg_bias, s_valid, s_data, m_ready,
    input  cfg_ready, s_ready, m_valid, m_score, m_class, m_tag
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_sv, cfg_alpha, cfg_bias_we, cfg_bias, s_valid, s_data, m_ready,
    output cfg_ready, s_ready, m_valid, m_score, m_class, m_tag
  );
endinterface

// File: rtl/svm_stream_classifier.sv
// svm_stream_classifier: streaming linear-kernel SVM, one support vector per cycle.
// Define SATURATE_EN to clamp terms and sums instead of wrapping modulo 2^ACCUM_W.
module svm_stream_classifier #(
  parameter int DATA_W   = 16,
  parameter int ACCUM_W  = 40,
  parameter int NUM_FEAT = 2,
  parameter int NUM_SV   = 3,
  parameter int TAG_W    = 8
) (
  input logic clk,
  input logic rst,
  svm_stream_classifier_if.slave bus
);
  localparam int SW = NUM_SV > 1 ? $clog2(NUM_SV) : 1;
  localparam int PW = 3 * DATA_W + $clog2(NUM_FEAT) + 2;
  localparam int W  = (PW > ACCUM_W ? PW : ACCUM_W) + 2;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  sv_q [NUM_SV][NUM_FEAT];
  logic signed [DATA_W-1:0]  sv_d [NUM_SV][NUM_FEAT];
  logic signed [DATA_W-1:0]  alpha_q [NUM_SV];
  logic signed [DATA_W-1:0]  alpha_d [NUM_SV];
  logic signed [DATA_W-1:0]  x_q [NUM_FEAT];
  logic signed [DATA_W-1:0]  x_d [NUM_FEAT];
  logic signed [DATA_W-1:0]  bias_q, bias_d;
  logic signed [ACCUM_W-1:0] acc_q, acc_d, score_q, score_d;
  logic [SW-1:0]             sv_i_q, sv_i_d;
  logic [TAG_W-1:0]          tag_q, tag_d;
  logic signed [W-1:0]       dot;
  logic signed [ACCUM_W-1:0] term, sum, total;
  logic                      cfg_ok;

  // Values arrive wide enough to be exact; bring them back into ACCUM_W.
  function automatic logic signed [ACCUM_W-1:0] reduce(input logic signed [W-1:0] v);
`ifdef SATURATE_EN
    return (&v[W-1:ACCUM_W-1] || ~|v[W-1:ACCUM_W-1]) ? v[ACCUM_W-1:0] :
           v[W-1] ? {1'b1, {(ACCUM_W-1){1'b0}}} : {1'b0, {(ACCUM_W-1){1'b1}}};
`else
    return v[ACCUM_W-1:0];
`endif
  endfunction

  assign cfg_ok        = state_q == IDLE;
  assign bus.cfg_ready = cfg_ok;
  assign bus.s_ready   = cfg_ok;
  assign bus.m_valid   = state_q == OUT;
  assign bus.m_score   = score_q;
  assign bus.m_class   = (state_q == OUT) && !score_q[ACCUM_W-1];
  assign bus.m_tag     = tag_q;

  always_comb begin
    dot = '0;
    for (int f = 0; f < NUM_FEAT; f++) dot = dot + W'(sv_q[sv_i_q][f]) * W'(x_q[f]);
    term  = reduce(dot * W'(alpha_q[sv_i_q]));
    sum   = reduce(W'(acc_q) + W'(term));
    total = reduce(W'(sum) + W'(bias_q));
  end

  always_comb begin
    state_d = state_q;
    sv_d    = sv_q;
    alpha_d = alpha_q;
    bias_d  = bias_q;
    x_d     = x_q;
    acc_d   = acc_q;
    score_d = score_q;
    sv_i_d  = sv_i_q;
    tag_d   = tag_q;
    for (int k = 0; k < NUM_SV; k++)
      if (cfg_ok && bus.cfg_we && int'(bus.cfg_addr) == k) begin
        alpha_d[k] = bus.cfg_alpha;
        for (int f = 0; f < NUM_FEAT; f++) sv_d[k][f] = bus.cfg_sv[f*DATA_W +: DATA_W];
      end
    if (cfg_ok && bus.cfg_bias_we) bias_d = bus.cfg_bias;
    case (state_q)
      IDLE: if (bus.s_valid) begin
        for (int f = 0; f < NUM_FEAT; f++) x_d[f] = bus.s_data[f*DATA_W +: DATA_W];
        acc_d   = '0;
        sv_i_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = sum;
        if (sv_i_q == SW'(NUM_SV - 1)) begin
          score_d = total;
          state_d = OUT;
        end else sv_i_d = sv_i_q + 1'b1;
      end
      OUT: if (bus.m_ready) begin
        tag_d   = tag_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sv_q    <= '{default: '0};
      alpha_q <= '{default: '0};
      x_q     <= '{default: '0};
      bias_q  <= '0;
      acc_q   <= '0;
      score_q <= '0;
      sv_i_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      sv_q    <= sv_d;
      alpha_q <= alpha_d;
      x_q     <= x_d;
      bias_q  <= bias_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      sv_i_q  <= sv_i_d;
      tag_q   <= tag_d;
    end
  end
endmodule
